decode_writeback: RTL and testbench

// - Y86-64 SEQ register file plus decode/writeback control. Sits downstream of memory stage and upstream of execute.
// - Decodes icode/rA/rB/Cnd into srcA/srcB/dstE/dstM and reads valA/valB combinationally.
// - Commits valE (from execute) and valM (from memory stage) on the rising clock edge.

---
 rtl/decode_writeback.sv | 145 ++++++++++++++
 tb/tb_decode_writeback.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_writeback.sv
// decode_writeback: Y86-64 SEQ register file with decode and writeback control.
// Decodes icode/rA/rB/Cnd into register ids and reads two operands combinationally.
// It commits valE/valM on the rising clock edge. When both target one register, valM wins.
// Ports:
//   clk, reset            clock; asynchronous active-high reset (restores reset contents)
//   wb_en                 writeback enable (0 = stall)
//   icode, rA, rB, Cnd    instruction fields and the execute condition
//   valE, valM            ALU result / memory data to commit
//   valA, valB            operand reads (0 for id F)
//   srcA, srcB, dstE, dstM decoded register ids (F = none)
// Optional build macro REGFILE_DEBUG_EN adds dbg_addr/dbg_data (debug read port)
// and wr_count (number of committed register writes).
module decode_writeback #(
    parameter int unsigned     WIDTH   = 64,
    parameter int unsigned     NREGS   = 15,
    parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(1024)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_en,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             Cnd,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic [3:0]       srcA,
    output logic [3:0]       srcB,
    output logic [3:0]       dstE,
    output logic [3:0]       dstM
`ifdef REGFILE_DEBUG_EN
    ,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [31:0]      wr_count
`endif
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    logic [WIDTH-1:0] regs [NREGS];
    logic             eValid;
    logic             mValid;

    // Combinational decode of source and destination ids
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            4'h2: begin                      // rrmovq / cmovXX
                srcA = rA;
                dstE = Cnd ? rB : RNONE;
            end
            4'h3: dstE = rB;                 // irmovq
            4'h4: begin                      // rmmovq
                srcA = rA;
                srcB = rB;
            end
            4'h5: begin                      // mrmovq
                srcB = rB;
                dstM = rA;
            end
            4'h6: begin                      // OPq
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            4'h8: begin                      // call
                srcB = RSP;
                dstE = RSP;
            end
            4'h9: begin                      // ret
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            4'hA: begin                      // pushq
                srcA = rA;
                srcB = RSP;
                dstE = RSP;
            end
            4'hB: begin                      // popq
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = rA;
            end
            default: ;
        endcase
    end

    // An id only addresses storage when it is below NREGS (which also excludes F)
    assign eValid = (32'(dstE) < NREGS);
    assign mValid = (32'(dstM) < NREGS);

    assign valA = (32'(srcA) < NREGS) ? regs[srcA] : '0;
    assign valB = (32'(srcB) < NREGS) ? regs[srcB] : '0;

    // Register file; M port checked first so popq %rsp keeps valM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (4'(i) == RSP) ? SP_INIT : '0;
            end
        end else if (wb_en) begin
            for (int i = 0; i < NREGS; i++) begin
                if (mValid && (dstM == 4'(i))) begin
                    regs[i] <= valM;
                end else if (eValid && (dstE == 4'(i))) begin
                    regs[i] <= valE;
                end
            end
        end
    end

`ifdef REGFILE_DEBUG_EN
    logic [1:0] wrInc;

    assign dbg_data = (32'(dbg_addr) < NREGS) ? regs[dbg_addr] : '0;

    // Two writes only when E and M land in different registers
    always_comb begin
        wrInc = 2'd0;
        if (eValid && mValid && (dstE != dstM)) begin
            wrInc = 2'd2;
        end else if (eValid || mValid) begin
            wrInc = 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
        end else if (wb_en) begin
            wr_count <= wr_count + 32'(wrInc);
        end
    end
`endif

endmodule

// File: tb/tb_decode_writeback.sv
module tb_decode_writeback;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        wb_en = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic [3:0]  rA    = 4'h0;
    logic [3:0]  rB    = 4'h0;
    logic        Cnd   = 1'b0;
    logic [63:0] valE  = '0;
    logic [63:0] valM  = '0;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
`ifdef REGFILE_DEBUG_EN
    logic [3:0]  dbg_addr = 4'h0;
    logic [63:0] dbg_data;
    logic [31:0] wr_count;
`endif

    decode_writeback dut (
        .clk      (clk),
        .reset    (reset),
        .wb_en    (wb_en),
        .icode    (icode),
        .rA       (rA),
        .rB       (rB),
        .Cnd      (Cnd),
        .valE     (valE),
        .valM     (valM),
        .valA     (valA),
        .valB     (valB),
        .srcA     (srcA),
        .srcB     (srcB),
        .dstE     (dstE),
        .dstM     (dstM)
`ifdef REGFILE_DEBUG_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_count (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: 16 slots so id F simply reads a never-written zero
    logic [63:0] mdl [16];
    int unsigned mdlCount;

    typedef struct {
        logic [3:0]  ic;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        c;
        logic [15:0] exp;   // {srcA, srcB, dstE, dstM}
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Decode rules straight from the instruction-set table
    function automatic logic [15:0] refDecode(input logic [3:0] ic, input logic [3:0] a,
                                              input logic [3:0] b, input logic c);
        logic [3:0] sa, sb, de, dm;
        sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? a : (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
        sb = (ic inside {4'h4, 4'h5, 4'h6}) ? b : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        de = (ic == 4'h2) ? (c ? b : 4'hF) : (ic inside {4'h3, 4'h6}) ? b :
             (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        dm = (ic inside {4'h5, 4'hB}) ? a : 4'hF;
        return {sa, sb, de, dm};
    endfunction

    task automatic mdlReset();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        mdl[4]   = 64'd1024;
        mdlCount = 0;
    endtask

    task automatic setIn(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [63:0] e, input logic [63:0] m, input logic w);
        icode = ic; rA = a; rB = b; Cnd = c; valE = e; valM = m; wb_en = w;
        #1;
    endtask

    // One clock edge; model commits E then M so M overrides on a shared id
    task automatic tick();
        logic [15:0] d;
        logic [3:0]  e, m;
        @(posedge clk);
        if (!reset && wb_en) begin
            d = refDecode(icode, rA, rB, Cnd);
            e = d[7:4];
            m = d[3:0];
            if (e != 4'hF) begin mdl[e] = valE; mdlCount++; end
            if (m != 4'hF) begin mdl[m] = valM; if (m != e) mdlCount++; end
        end
        @(negedge clk);
    endtask

    task automatic checkOuts(input string tag);
        logic [15:0] d;
        d = refDecode(icode, rA, rB, Cnd);
        chk({tag, "_decode"}, 64'({srcA, srcB, dstE, dstM}), 64'(d));
        chk({tag, "_valA"}, valA, mdl[d[15:12]]);
        chk({tag, "_valB"}, valB, mdl[d[11:8]]);
`ifdef REGFILE_DEBUG_EN
        chk({tag, "_dbg"}, dbg_data, mdl[dbg_addr]);
        chk({tag, "_wrcnt"}, 64'(wr_count), 64'(mdlCount));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{4'h0, 4'h1, 4'h3, 1'b0, 16'hFFFF};
        tbl[1]  = '{4'h1, 4'h1, 4'h3, 1'b0, 16'hFFFF};
        tbl[2]  = '{4'h2, 4'h1, 4'h3, 1'b0, 16'h1FFF};
        tbl[3]  = '{4'h2, 4'h1, 4'h3, 1'b1, 16'h1F3F};
        tbl[4]  = '{4'h3, 4'h1, 4'h3, 1'b0, 16'hFF3F};
        tbl[5]  = '{4'h4, 4'h1, 4'h3, 1'b0, 16'h13FF};
        tbl[6]  = '{4'h5, 4'h1, 4'h3, 1'b0, 16'hF3F1};
        tbl[7]  = '{4'h6, 4'h1, 4'h3, 1'b1, 16'h133F};
        tbl[8]  = '{4'h7, 4'h1, 4'h3, 1'b1, 16'hFFFF};
        tbl[9]  = '{4'h8, 4'h1, 4'h3, 1'b0, 16'hF44F};
        tbl[10] = '{4'h9, 4'h1, 4'h3, 1'b0, 16'h444F};
        tbl[11] = '{4'hA, 4'h1, 4'h3, 1'b0, 16'h144F};
        tbl[12] = '{4'hB, 4'h1, 4'h3, 1'b0, 16'h4441};
        tbl[13] = '{4'hC, 4'h1, 4'h3, 1'b1, 16'hFFFF};
        tbl[14] = '{4'hF, 4'h1, 4'h3, 1'b1, 16'hFFFF};

        mdlReset();
        repeat (2) @(negedge clk);

        // While held in reset: reads return reset contents, decode stays live
        setIn(4'hA, 4'h0, 4'h0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("rst_srcB", 64'(srcB), 64'd4);
        chk("rst_valB", valB, 64'd1024);
        chk("rst_valA", valA, 64'd0);
`ifdef REGFILE_DEBUG_EN
        chk("rst_wrcnt", 64'(wr_count), 64'd0);
`endif
        // Edge with reset high must not write
        setIn(4'h3, 4'h0, 4'h2, 1'b0, 64'd55, 64'd0, 1'b1);
        tick();
        setIn(4'h6, 4'h2, 4'h0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("rst_nowrite", valA, 64'd0);

        reset = 1'b0;
        setIn(4'hA, 4'h0, 4'h0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("rel_srcB", 64'(srcB), 64'd4);
        chk("rel_valB", valB, 64'd1024);
        chk("rel_valA", valA, 64'd0);

        // Decode table, no writes
        for (int i = 0; i < 15; i++) begin
            setIn(tbl[i].ic, tbl[i].a, tbl[i].b, tbl[i].c, 64'd0, 64'd0, 1'b0);
            chk($sformatf("tbl%0d", i), 64'({srcA, srcB, dstE, dstM}), 64'(tbl[i].exp));
        end

        // irmovq then cmov read-back
        setIn(4'h3, 4'hF, 4'h2, 1'b0, 64'd5, 64'd0, 1'b1);
        tick();
        setIn(4'h2, 4'h2, 4'h3, 1'b1, 64'd0, 64'd0, 1'b0);
        chk("irmov_valA", valA, 64'd5);

        // cmov not taken, then taken
        setIn(4'h2, 4'h2, 4'h3, 1'b0, 64'd9, 64'd0, 1'b1);
        chk("cmov0_dstE", 64'(dstE), 64'hF);
        tick();
        setIn(4'h6, 4'h3, 4'h0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("cmov0_R3", valA, 64'd0);
        setIn(4'h2, 4'h2, 4'h3, 1'b1, 64'd9, 64'd0, 1'b1);
        tick();
        setIn(4'h6, 4'h3, 4'h0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("cmov1_R3", valA, 64'd9);

        // popq %rsp: M wins
        setIn(4'hB, 4'h4, 4'hF, 1'b0, 64'd1032, 64'd77, 1'b1);
        tick();
        setIn(4'h6, 4'h4, 4'h0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("popq_rsp", valA, 64'd77);

        // Stall holds R[1]
        setIn(4'h3, 4'hF, 4'h1, 1'b0, 64'd123, 64'd0, 1'b1);
        tick();
        setIn(4'h6, 4'h0, 4'h1, 1'b0, 64'd8, 64'd0, 1'b0);
        tick();
        setIn(4'h6, 4'h1, 4'h4, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("stall_R1", valA, 64'd123);

        // Asynchronous reset pulse between edges
        reset = 1'b1;
        #1;
        chk("arst_R1", valA, 64'd0);
        chk("arst_R4", valB, 64'd1024);
        reset = 1'b0;
        mdlReset();
        #1;

        // mrmovq then popq with rA=5: counts 1 then 3
        setIn(4'h5, 4'h7, 4'hF, 1'b0, 64'd0, 64'd3, 1'b1);
        tick();
        setIn(4'h6, 4'h7, 4'h0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("mrmov_R7", valA, 64'd3);
`ifdef REGFILE_DEBUG_EN
        dbg_addr = 4'h7;
        #1;
        chk("dbg_R7", dbg_data, 64'd3);
        chk("dbg_cnt1", 64'(wr_count), 64'd1);
`endif
        setIn(4'hB, 4'h5, 4'hF, 1'b0, 64'd2000, 64'd66, 1'b1);
        tick();
        setIn(4'h6, 4'h5, 4'h4, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("popq5_R5", valA, 64'd66);
        chk("popq5_R4", valB, 64'd2000);
`ifdef REGFILE_DEBUG_EN
        chk("dbg_cnt3", 64'(wr_count), 64'd3);
`endif

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                #1;
                reset = 1'b0;
                mdlReset();
            end
`ifdef REGFILE_DEBUG_EN
            dbg_addr = 4'($urandom_range(0, 15));
`endif
            setIn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 3) != 0));
            checkOuts($sformatf("rnd%0d", n));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
